// File: rtl/priority_encoder_stream.sv
// Streaming priority encoder: accepts a bitmap and emits one beat per set bit, in LSB- or MSB-first order.
// Optional PENC_STREAM_COUNT_EN adds out_count, the popcount of the captured bitmap.
module priority_encoder_stream #(
    parameter int WIDTH     = 32,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
`ifdef PENC_STREAM_COUNT_EN
    ,
    output logic [IDX_W:0]   out_count
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] pending;
    logic             zero_q;
    logic [IDX_W-1:0] sel_idx;
    logic [WIDTH-1:0] sel_mask;
    logic             single_bit;
    logic             accept;
    logic             fire;

    // Pick the bit to emit this beat; the last matching iteration wins, so the loop
    // direction decides the priority order.
    always_comb begin
        sel_idx  = '0;
        sel_mask = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending[i]) begin
                    sel_idx     = IDX_W'(i);
                    sel_mask    = '0;
                    sel_mask[i] = 1'b1;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    sel_idx     = IDX_W'(i);
                    sel_mask    = '0;
                    sel_mask[i] = 1'b1;
                end
            end
        end
    end

    assign single_bit = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

    assign out_valid = (state == EMIT);
    assign out_idx   = sel_idx;
    assign out_last  = out_valid && (zero_q || single_bit);
    assign out_zero  = out_valid && zero_q;
    assign fire      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (fire && out_last);
    assign accept    = in_valid && in_ready;

    // A new capture takes precedence over retiring the final beat, giving back-to-back bitmaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            state   <= EMIT;
            pending <= in_vec;
            zero_q  <= (in_vec == '0);
        end else if (fire) begin
            pending <= pending & ~sel_mask;
            if (out_last) begin
                state  <= IDLE;
                zero_q <= 1'b0;
            end
        end
    end

`ifdef PENC_STREAM_COUNT_EN
    logic [IDX_W:0] in_popcount;

    always_comb begin
        in_popcount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_popcount = in_popcount + (IDX_W + 1)'(in_vec[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (accept) begin
            out_count <= in_popcount;
        end
    end
`endif

endmodule

// File: tb/tb_priority_encoder_stream.sv
// Randomized bench for priority_encoder_stream: LSB-first and MSB-first instances checked against a beat-queue model.
// Define PENC_STREAM_COUNT_EN to also check out_count.
module tb_priority_encoder_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_vec;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_last0, out_zero0;
    logic [4:0]  out_idx0;
    logic        in_ready1, out_valid1, out_last1, out_zero1;
    logic [4:0]  out_idx1;
`ifdef PENC_STREAM_COUNT_EN
    logic [5:0]  out_count0, out_count1;
`endif

    int checks = 0;
    int errors = 0;

    int q0[$];
    int q1[$];
    logic mzero = 1'b0;
    int mcount = 0;

    priority_encoder_stream #(.WIDTH(32), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_vec(in_vec),
        .out_valid(out_valid0), .out_ready(out_ready), .out_idx(out_idx0),
        .out_last(out_last0), .out_zero(out_zero0)
`ifdef PENC_STREAM_COUNT_EN
        , .out_count(out_count0)
`endif
    );

    priority_encoder_stream #(.WIDTH(32), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_vec(in_vec),
        .out_valid(out_valid1), .out_ready(out_ready), .out_idx(out_idx1),
        .out_last(out_last1), .out_zero(out_zero1)
`ifdef PENC_STREAM_COUNT_EN
        , .out_count(out_count1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected beat lists are just the set-bit positions sorted in each priority order.
    task automatic loadModel(input logic [31:0] vec);
        q0.delete();
        q1.delete();
        mcount = $countones(vec);
        mzero  = (vec == 32'h0);
        if (vec == 32'h0) begin
            q0.push_back(0);
            q1.push_back(0);
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (vec[i]) begin
                    q0.push_back(i);
                    q1.push_front(i);
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] vec, input logic ordy);
        logic exp_valid, exp_last, exp_ready;
        @(negedge clk);
        in_valid  = v;
        in_vec    = vec;
        out_ready = ordy;
        #1;
        exp_valid = (q0.size() != 0);
        exp_last  = (q0.size() == 1);
        exp_ready = !exp_valid || (ordy && exp_last);
        checkOutput("valid_lsb", 64'(out_valid0), 64'(exp_valid));
        checkOutput("valid_msb", 64'(out_valid1), 64'(exp_valid));
        checkOutput("ready_lsb", 64'(in_ready0), 64'(exp_ready));
        checkOutput("ready_msb", 64'(in_ready1), 64'(exp_ready));
        if (exp_valid) begin
            checkOutput("idx_lsb", 64'(out_idx0), 64'(q0[0]));
            checkOutput("idx_msb", 64'(out_idx1), 64'(q1[0]));
            checkOutput("last_lsb", 64'(out_last0), 64'(exp_last));
            checkOutput("last_msb", 64'(out_last1), 64'(exp_last));
            checkOutput("zero_lsb", 64'(out_zero0), 64'(mzero));
            checkOutput("zero_msb", 64'(out_zero1), 64'(mzero));
`ifdef PENC_STREAM_COUNT_EN
            checkOutput("count_lsb", 64'(out_count0), 64'(mcount));
            checkOutput("count_msb", 64'(out_count1), 64'(mcount));
`endif
        end
        if (exp_valid && ordy) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (v && exp_ready) loadModel(vec);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 64'({out_valid0, out_valid1}), 64'(0));
        checkOutput({tag, "_idx"},   64'({out_idx0, out_idx1}), 64'(0));
        checkOutput({tag, "_last"},  64'({out_last0, out_last1}), 64'(0));
        checkOutput({tag, "_zero"},  64'({out_zero0, out_zero1}), 64'(0));
`ifdef PENC_STREAM_COUNT_EN
        checkOutput({tag, "_count"}, 64'({out_count0, out_count1}), 64'(0));
`endif
    endtask

    function automatic logic [31:0] randVec();
        int kind;
        kind = $urandom_range(0, 4);
        case (kind)
            0: randVec = 32'h0;
            1: randVec = 32'h1 << $urandom_range(0, 31);
            2: randVec = $urandom() & $urandom() & $urandom();
            default: randVec = $urandom();
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 32'h0;
        out_ready = 1'b0;
        #3;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 32'h0, 1'b1);
        // One-hot, then multi-hot in both orders from the two instances
        applyStimulus(1'b1, 32'h0000_0400, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h8000_0011, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        // Zero bitmap
        applyStimulus(1'b1, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        // Backpressure, then a new bitmap accepted on the final beat
        applyStimulus(1'b1, 32'h0000_0006, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0000_0001, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0001, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Reset in the middle of a full bitmap, away from any clock edge
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        q0.delete();
        q1.delete();
        mzero = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 34; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randVec(), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
